serial_adder: RTL

- Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in, adds one bit per clock LSB-first, and returns a WIDTH-bit sum and carry-out.
- The addition counterpart of the team's subtractor blocks. Used where area matters more than latency, and as the reconstruction path (minuend = difference + subtrahend) in subtractor self-check benches.
- Per-bit datapath is a full adder built from two half adders: carry = c1 | c2.

---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 92 +++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand bus for serial_adder.
// SERIAL_ADDER_SUB_MODE_EN adds the mode (add/subtract) select signal.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    logic             mode;

    modport master (output start, a, b, cin, mode, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, mode, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder bit per clock, result published on entry to DONE.
// SERIAL_ADDER_SUB_MODE_EN adds a subtract mode (a - b - cin, cout = final borrow).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    logic             mode_q;
`endif

    // Per-bit cell: two half adders; in subtract mode the carry becomes a borrow.
    logic h1, c1, c2, bit_s, bit_c;
    always_comb begin
        h1    = a_sh[0] ^ b_sh[0];
        c1    = a_sh[0] & b_sh[0];
        bit_s = h1 ^ carry;
        c2    = h1 & carry;
        bit_c = c1 | c2;
`ifdef SERIAL_ADDER_SUB_MODE_EN
        if (mode_q)
            bit_c = (~a_sh[0] & b_sh[0]) | (~h1 & carry);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.sum   <= '0;
            bus.cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
`ifdef SERIAL_ADDER_SUB_MODE_EN
                        mode_q   <= bus.mode;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry  <= bit_c;
                    sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // The last bit goes straight to the output so sum is never seen partial.
                    if (cnt == LAST) begin
                        bus.sum  <= {bit_s, sum_sh[WIDTH-1:1]};
                        bus.cout <= bit_c;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
